// File: rtl/mem_pkg.sv
// Shared encodings for the memory access unit: op codes, exception causes,
// FSM states and the access-size decode used by the top and the lane aligner.
package mem_pkg;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LW   = 4'd1;
  localparam logic [3:0] OP_LH   = 4'd2;
  localparam logic [3:0] OP_LHU  = 4'd3;
  localparam logic [3:0] OP_LB   = 4'd4;
  localparam logic [3:0] OP_LBU  = 4'd5;
  localparam logic [3:0] OP_SW   = 4'd8;
  localparam logic [3:0] OP_SH   = 4'd9;
  localparam logic [3:0] OP_SB   = 4'd10;

  localparam logic [1:0] EXC_NONE   = 2'b00;
  localparam logic [1:0] EXC_ADEL   = 2'b01;
  localparam logic [1:0] EXC_ADES   = 2'b10;
  localparam logic [1:0] EXC_BUSERR = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_DONE, ST_EXC} state_t;
  typedef enum logic [1:0] {SZ_NONE, SZ_B, SZ_H, SZ_W} size_t;

  // Unlisted codes decode to SZ_NONE so they behave exactly like OP_NONE.
  function automatic size_t op_size(input logic [3:0] op);
    case (op)
      OP_LW, OP_SW:          op_size = SZ_W;
      OP_LH, OP_LHU, OP_SH:  op_size = SZ_H;
      OP_LB, OP_LBU, OP_SB:  op_size = SZ_B;
      default:               op_size = SZ_NONE;
    endcase
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    is_store = (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic is_unsigned(input logic [3:0] op);
    is_unsigned = (op == OP_LHU) || (op == OP_LBU);
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Combinational little-endian lane handling: byte enables and replicated
// write data for stores, lane extraction and sign/zero extension for loads.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic [31:0] load_data
);

  size_t       size;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign size  = op_size(op);
  assign rhalf = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    case (addr_lo)
      2'd0:    rbyte = rdata[7:0];
      2'd1:    rbyte = rdata[15:8];
      2'd2:    rbyte = rdata[23:16];
      default: rbyte = rdata[31:24];
    endcase
  end

  always_comb begin
    be         = 4'b0000;
    lane_wdata = 32'd0;
    load_data  = 32'd0;
    case (size)
      SZ_W: begin
        be         = 4'b1111;
        lane_wdata = wdata;
        load_data  = rdata;
      end
      SZ_H: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata[15:0]}};
        load_data  = is_unsigned(op) ? {16'd0, rhalf} : {{16{rhalf[15]}}, rhalf};
      end
      SZ_B: begin
        be         = 4'b0001 << addr_lo;
        lane_wdata = {4{wdata[7:0]}};
        load_data  = is_unsigned(op) ? {24'd0, rbyte} : {{24{rbyte[7]}}, rbyte};
      end
      default: ;
    endcase
    // Stores never return data to the pipeline.
    if (is_store(op)) load_data = 32'd0;
  end

endmodule

// File: rtl/mem_access_unit.sv
// Pipeline memory stage with a req/ack data bus: stalls while an access is
// outstanding, raises alignment exceptions and a bus error on ack timeout.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int TIMEOUT_CYC   = 16,
  parameter int ZERO_LOW_ADDR = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [3:0]        in_mem_op,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_wdata,
  output logic              stall,
  output logic              out_valid,
  output logic [31:0]       out_rdata,
  output logic              out_exc,
  output logic [1:0]        out_exc_code,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_ack
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t            state, state_nx;
  logic [7:0]        wait_cnt;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic [1:0]        exc_q;

  size_t       in_size;
  logic        in_mem;
  logic        misaligned;
  logic        timeout_hit;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] load_data;

  assign in_size     = op_size(in_mem_op);
  assign in_mem      = (in_size != SZ_NONE);
  assign timeout_hit = (wait_cnt == TO_LAST);
  assign stall       = in_valid && in_mem && (state != ST_DONE) && (state != ST_EXC);

  always_comb begin
    case (in_size)
      SZ_W:    misaligned = |in_addr[1:0];
      SZ_H:    misaligned = in_addr[0];
      default: misaligned = 1'b0;
    endcase
  end

  mem_lane_align u_lane (
    .op         (op_q),
    .addr_lo    (addr_q[1:0]),
    .wdata      (wdata_q),
    .rdata      (rdata_q),
    .be         (lane_be),
    .lane_wdata (lane_wdata),
    .load_data  (load_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      wait_cnt <= 8'd0;
      op_q     <= OP_NONE;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      exc_q    <= EXC_NONE;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          if (in_valid && in_mem) begin
            op_q     <= in_mem_op;
            addr_q   <= in_addr;
            wdata_q  <= in_wdata;
            rdata_q  <= 32'd0;
            wait_cnt <= 8'd0;
            if (misaligned) exc_q <= is_store(in_mem_op) ? EXC_ADES : EXC_ADEL;
            else            exc_q <= EXC_NONE;
          end
        end
        ST_REQ: begin
          // An ack on the threshold cycle still completes normally.
          if (bus_ack) begin
            rdata_q <= bus_rdata;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (timeout_hit) exc_q <= EXC_BUSERR;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx     = state;
    out_valid    = 1'b0;
    out_rdata    = 32'd0;
    out_exc      = 1'b0;
    out_exc_code = EXC_NONE;
    bus_req      = 1'b0;
    bus_we       = 1'b0;
    bus_addr     = '0;
    bus_be       = 4'b0000;
    bus_wdata    = 32'd0;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          if (!in_mem)         out_valid = 1'b1;
          else if (misaligned) state_nx  = ST_EXC;
          else                 state_nx  = ST_REQ;
        end
      end
      ST_REQ: begin
        bus_req   = 1'b1;
        bus_we    = is_store(op_q);
        bus_addr  = (ZERO_LOW_ADDR != 0) ? {addr_q[ADDR_W-1:2], 2'b00} : addr_q;
        bus_be    = lane_be;
        bus_wdata = lane_wdata;
        if (bus_ack)          state_nx = ST_DONE;
        else if (timeout_hit) state_nx = ST_EXC;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        out_rdata = load_data;
        state_nx  = ST_IDLE;
      end
      ST_EXC: begin
        out_valid    = 1'b1;
        out_exc      = 1'b1;
        out_exc_code = exc_q;
        state_nx     = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: vector table plus random sub-word loads, with a
// result scoreboard fed at issue time and drained on out_valid.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [3:0]  in_mem_op;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        stall;
  logic        out_valid;
  logic [31:0] out_rdata;
  logic        out_exc;
  logic [1:0]  out_exc_code;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  int n_tests = 0;
  int n_fail  = 0;

  logic [34:0] exp_q[$];

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_delay;
    logic [3:0]  exp_be;
    logic [31:0] exp_bwdata;
    int          exp_stall;
    int          exp_req;
    logic        exp_exc;
    logic [1:0]  exp_code;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYC(16), .ZERO_LOW_ADDR(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_mem_op    (in_mem_op),
    .in_addr      (in_addr),
    .in_wdata     (in_wdata),
    .stall        (stall),
    .out_valid    (out_valid),
    .out_rdata    (out_rdata),
    .out_exc      (out_exc),
    .out_exc_code (out_exc_code),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_be       (bus_be),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_ack      (bus_ack)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Scoreboard: every out_valid must match the oldest pending expectation.
  always @(negedge clk) begin
    if (out_valid) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL result: unexpected out_valid exc=%0b code=%0d rdata=0x%08h",
                 out_exc, out_exc_code, out_rdata);
      end else begin
        logic [34:0] e;
        e = exp_q.pop_front();
        if ({out_exc, out_exc_code, out_rdata} !== e) begin
          n_fail++;
          $display("FAIL result: got exc=%0b code=%0d rdata=0x%08h expected exc=%0b code=%0d rdata=0x%08h",
                   out_exc, out_exc_code, out_rdata, e[34], e[33:32], e[31:0]);
        end
      end
    end
  end

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input int ack_delay, input logic [3:0] exp_be,
                              input logic [31:0] exp_bwdata, input int exp_stall,
                              input int exp_req, input logic exp_exc,
                              input logic [1:0] exp_code, input logic [31:0] exp_rdata);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.ack_delay = ack_delay; v.exp_be = exp_be; v.exp_bwdata = exp_bwdata;
    v.exp_stall = exp_stall; v.exp_req = exp_req; v.exp_exc = exp_exc;
    v.exp_code = exp_code; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [1:0] a,
                                           input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[8*a +: 8];
    h = a[1] ? d[31:16] : d[15:0];
    case (op)
      OP_LB:   return {{24{b[7]}}, b};
      OP_LBU:  return {24'd0, b};
      OP_LH:   return {{16{h[15]}}, h};
      OP_LHU:  return {16'd0, h};
      OP_LW:   return d;
      default: return 32'd0;
    endcase
  endfunction

  // Driver: issue one instruction, play the bus slave, check bus and stall.
  task automatic run_vec(input vec_t v, input int idx);
    int          stall_n;
    int          req_n;
    bit          done;
    bit          unstable;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_be;
    logic        s_we;
    logic        st;
    string       tag;
    stall_n  = 0;
    req_n    = 0;
    done     = 0;
    unstable = 0;
    s_addr = 0; s_wdata = 0; s_be = 0; s_we = 0;
    st  = (v.op == OP_SW) || (v.op == OP_SH) || (v.op == OP_SB);
    tag = $sformatf("v%0d", idx);
    exp_q.push_back({v.exp_exc, v.exp_code, v.exp_rdata});
    @(posedge clk); #1;
    in_valid  = 1'b1;
    in_mem_op = v.op;
    in_addr   = v.addr;
    in_wdata  = v.wdata;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (bus_req) begin
        req_n++;
        if (req_n == 1) begin
          s_addr = bus_addr; s_be = bus_be; s_we = bus_we; s_wdata = bus_wdata;
          chk({tag, " bus_addr"}, bus_addr, v.addr & 32'hFFFF_FFFC);
          chk({tag, " bus_be"}, {28'd0, bus_be}, {28'd0, v.exp_be});
          chk({tag, " bus_we"}, {31'd0, bus_we}, {31'd0, st});
          if (st) chk({tag, " bus_wdata"}, bus_wdata, v.exp_bwdata);
        end else if (bus_addr !== s_addr || bus_be !== s_be || bus_we !== s_we ||
                     bus_wdata !== s_wdata) begin
          unstable = 1;
        end
        if (req_n == v.ack_delay) begin
          bus_ack   = 1'b1;
          bus_rdata = v.rdata;
        end else begin
          bus_ack   = 1'b0;
          bus_rdata = $urandom;
        end
      end else begin
        bus_ack = 1'b0;
      end
      if (stall) stall_n++;
      else done = 1;
    end
    bus_ack = 1'b0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: stall never released within 60 cycles", tag);
    end
    chk({tag, " stall_cycles"}, stall_n, v.exp_stall);
    chk({tag, " req_cycles"}, req_n, v.exp_req);
    if (v.exp_req > 0) chk({tag, " bus_stable"}, {31'd0, unstable}, 32'd0);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_mem_op = OP_NONE;
  endtask

  initial begin
    vec_t v;
    bit   seen;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_mem_op = OP_NONE;
    in_addr   = 32'd0;
    in_wdata  = 32'd0;
    bus_rdata = 32'd0;
    bus_ack   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst out_exc", {31'd0, out_exc}, 32'd0);
    chk("rst stall", {31'd0, stall}, 32'd0);
    chk("rst bus_be", {28'd0, bus_be}, 32'd0);
    // Pass-through stays combinational even while reset is held.
    exp_q.push_back(35'd0);
    @(posedge clk); #1;
    in_valid = 1'b1;
    @(negedge clk);
    chk("rst passthru valid", {31'd0, out_valid}, 32'd1);
    chk("rst passthru stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset    = 1'b1;

    //         op       addr          wdata         rdata         ack be       bwdata        stl req exc code        rdata
    vecs.push_back(mk(OP_NONE, 32'h0000_0040, 32'h1111_1111, 32'h0,         0, 4'b0000, 32'h0,         0,  0, 0, EXC_NONE,   32'h0));
    vecs.push_back(mk(OP_SW,   32'h0000_0100, 32'hDEAD_BEEF, 32'h0,         3, 4'b1111, 32'hDEAD_BEEF, 4,  3, 0, EXC_NONE,   32'h0));
    vecs.push_back(mk(OP_LB,   32'h0000_0203, 32'h0,         32'h8011_2233, 1, 4'b1000, 32'h0,         2,  1, 0, EXC_NONE,   32'hFFFF_FF80));
    vecs.push_back(mk(OP_LBU,  32'h0000_0203, 32'h0,         32'h8011_2233, 1, 4'b1000, 32'h0,         2,  1, 0, EXC_NONE,   32'h0000_0080));
    vecs.push_back(mk(OP_SH,   32'h0000_0102, 32'h0000_ABCD, 32'h0,         2, 4'b1100, 32'hABCD_ABCD, 3,  2, 0, EXC_NONE,   32'h0));
    vecs.push_back(mk(OP_LH,   32'h0000_0102, 32'h0,         32'h7F00_0000, 1, 4'b1100, 32'h0,         2,  1, 0, EXC_NONE,   32'h0000_7F00));
    vecs.push_back(mk(OP_LW,   32'h0000_0102, 32'h0,         32'h0,         0, 4'b0000, 32'h0,         1,  0, 1, EXC_ADEL,   32'h0));
    vecs.push_back(mk(OP_SH,   32'h0000_0101, 32'h0,         32'h0,         0, 4'b0000, 32'h0,         1,  0, 1, EXC_ADES,   32'h0));
    vecs.push_back(mk(OP_LHU,  32'h0000_0100, 32'h0,         32'h1234_F00D, 2, 4'b0011, 32'h0,         3,  2, 0, EXC_NONE,   32'h0000_F00D));
    vecs.push_back(mk(OP_LH,   32'h0000_0100, 32'h0,         32'h1234_F00D, 2, 4'b0011, 32'h0,         3,  2, 0, EXC_NONE,   32'hFFFF_F00D));
    vecs.push_back(mk(OP_SB,   32'h0000_0101, 32'h0000_00A5, 32'h0,         1, 4'b0010, 32'hA5A5_A5A5, 2,  1, 0, EXC_NONE,   32'h0));
    vecs.push_back(mk(OP_SB,   32'h0000_0303, 32'h1234_5677, 32'h0,         1, 4'b1000, 32'h7777_7777, 2,  1, 0, EXC_NONE,   32'h0));
    vecs.push_back(mk(OP_LW,   32'h0000_03FC, 32'h0,         32'hCAFE_BABE, 1, 4'b1111, 32'h0,         2,  1, 0, EXC_NONE,   32'hCAFE_BABE));
    vecs.push_back(mk(OP_LB,   32'h0000_0201, 32'h0,         32'h8011_2233, 1, 4'b0010, 32'h0,         2,  1, 0, EXC_NONE,   32'h0000_0022));
    vecs.push_back(mk(4'd6,    32'h0000_0003, 32'h0,         32'h0,         0, 4'b0000, 32'h0,         0,  0, 0, EXC_NONE,   32'h0));
    vecs.push_back(mk(OP_SW,   32'h0000_0101, 32'h0,         32'h0,         0, 4'b0000, 32'h0,         1,  0, 1, EXC_ADES,   32'h0));
    // Timeout: never acked, then acked on the final REQ cycle.
    vecs.push_back(mk(OP_LW,   32'h0000_0010, 32'h0,         32'h0,         0, 4'b1111, 32'h0,        17, 16, 1, EXC_BUSERR, 32'h0));
    vecs.push_back(mk(OP_LW,   32'h0000_0010, 32'h0,         32'h1111_2222, 16, 4'b1111, 32'h0,       17, 16, 0, EXC_NONE,   32'h1111_2222));

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Random sub-word loads
    for (int i = 0; i < 8; i++) begin
      logic [3:0]  op;
      logic [1:0]  a;
      logic [31:0] d;
      int          dl;
      case ($urandom_range(0, 3))
        0:       op = OP_LB;
        1:       op = OP_LBU;
        2:       op = OP_LH;
        default: op = OP_LHU;
      endcase
      a = 2'($urandom_range(0, 3));
      if (op == OP_LH || op == OP_LHU) a[0] = 1'b0;
      d  = $urandom;
      dl = $urandom_range(1, 4);
      v = mk(op, {20'h00000, 4'($urandom_range(0, 15)), 6'd0, a}, 32'h0, d, dl,
             (op == OP_LH || op == OP_LHU) ? (a[1] ? 4'b1100 : 4'b0011) : (4'b0001 << a),
             32'h0, dl + 1, dl, 1'b0, EXC_NONE, ref_load(op, a, d));
      run_vec(v, 100 + i);
    end

    // Reset in the middle of a request
    @(posedge clk); #1;
    in_valid  = 1'b1;
    in_mem_op = OP_LW;
    in_addr   = 32'h0000_0020;
    seen = 0;
    for (int c = 0; c < 5 && !seen; c++) begin
      @(negedge clk);
      if (bus_req) seen = 1;
    end
    chk("mid_rst reached REQ", {31'd0, seen}, 32'd1);
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_mem_op = OP_NONE;
    @(negedge clk);
    chk("mid_rst bus_req", {31'd0, bus_req}, 32'd0);
    chk("mid_rst stall", {31'd0, stall}, 32'd0);
    reset     = 1'b1;
    bus_ack   = 1'b1;
    bus_rdata = 32'h5A5A_5A5A;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("stray_ack out_valid", {31'd0, out_valid}, 32'd0);
    chk("stray_ack bus_req", {31'd0, bus_req}, 32'd0);
    @(negedge clk);
    chk("stray_ack out_valid later", {31'd0, out_valid}, 32'd0);
    run_vec(mk(OP_NONE, 32'h0, 32'h0, 32'h0, 0, 4'b0000, 32'h0, 0, 0, 1'b0, EXC_NONE, 32'h0), 200);

    repeat (2) @(negedge clk);
    chk("scoreboard drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
